// File: rtl/obuf_tx.sv
// Snoops core byte writes into the output buffer window and sends them as 8N1 frames on tx_o.
// Capture is one edge; the FIFO never stalls the core, drops on overrun and flags it in ovf_o.

module obuf_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_dat,
  output logic [W-1:0]             o_dat,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_cnt   = r_cnt;
  assign o_dat   = r_mem[r_rp];

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push then.
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && !w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_dat;
  end

endmodule

module obuf_tx #(
  parameter int OBUF  = 'h1400,
  parameter int OBSZ  = 'h600,
  parameter int ASZ   = 17,
  parameter int DEPTH = 16,
  parameter int DIV   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_i,
  input  logic [ASZ-1:0]         addr_i,
  input  logic [7:0]             data_i,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   full_o,
  output logic                   ovf_o,
  output logic [$clog2(DEPTH):0] cnt_o
);

  localparam int BCW = $clog2(DIV);
  localparam logic [ASZ:0] P_LO = (ASZ+1)'(OBUF);
  localparam logic [ASZ:0] P_HI = (ASZ+1)'(OBUF + OBSZ);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [BCW-1:0]   r_bc;
  logic [2:0]       r_bi;
  logic [7:0]       r_sh;
  logic             r_tx;
  logic             r_ovf;

  logic             w_hit;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_empty;
  logic             w_full;
  logic             w_bc_end;
  logic             w_tx_nxt;
  logic [7:0]       w_fifo_dat;
  logic [$clog2(DEPTH):0] w_cnt;

  // Extra top bit keeps OBUF+OBSZ from wrapping at the top of the address space.
  assign w_hit  = ({1'b0, addr_i} >= P_LO) && ({1'b0, addr_i} < P_HI);
  assign w_push = write_i && w_hit && !rst;

  obuf_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (data_i),
    .o_dat   (w_fifo_dat),
    .o_cnt   (w_cnt),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign w_bc_end = (r_bc == BCW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_bc    <= '0;
      r_bi    <= '0;
      r_sh    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_tx    <= w_tx_nxt;
      r_bc    <= (r_state == IDLE || w_bc_end) ? '0 : r_bc + 1'b1;
      if (r_state == START && w_bc_end)
        r_bi <= '0;
      else if (r_state == DATA && w_bc_end)
        r_bi <= r_bi + 1'b1;
      if (w_pop)
        r_sh <= w_fifo_dat;
      else if (r_state == DATA && w_bc_end)
        r_sh <= {1'b0, r_sh[7:1]};
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_nxt = START;
      START:   if (w_bc_end) w_nxt = DATA;
      DATA:    if (w_bc_end && r_bi == 3'd7) w_nxt = STOP;
      STOP:    if (w_bc_end) w_nxt = w_empty ? IDLE : START;
      default: w_nxt = IDLE;
    endcase
  end

  // tx is registered, so its next value is taken from where the FSM is heading.
  always_comb begin
    w_pop    = 1'b0;
    w_tx_nxt = 1'b1;
    if (!w_empty && (r_state == IDLE || (r_state == STOP && w_bc_end)))
      w_pop = 1'b1;
    case (w_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = (r_state == DATA && w_bc_end) ? r_sh[1] : r_sh[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign tx_o   = r_tx;
  assign busy_o = (r_state != IDLE);
  assign full_o = w_full;
  assign ovf_o  = r_ovf;
  assign cnt_o  = w_cnt;

endmodule

// File: doc/obuf_tx.md
# obuf_tx

Serial console transmitter that snoops the eJ32 byte-wide memory write bus. It captures every byte the core stores into the output buffer window (OBUF..OBUF+OBSZ-1) into a small FIFO. It then emits each byte as an 8N1 asynchronous serial frame on `tx_o`. It sits downstream of eJ32 in parallel with the spram8_128k write path and never stalls or back-pressures the core.

## Interface
Parameters:
- `OBUF`, 'h1400, base byte address of output buffer window
- `OBSZ`, 'h600, window size in bytes; captured range is [OBUF, OBUF+OBSZ)
- `ASZ`, 17, address width
- `DEPTH`, 16, FIFO entries (power of two, ≥2)
- `DIV`, 4, clock cycles per serial bit (≥2)

Ports:
- `clk`  in  1  system clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `write_i`  in  1  core write strobe (eJ32 `write_o`)
- `addr_i`  in  ASZ  core byte address (eJ32 `addr_o_o`)
- `data_i`  in  8  core write data (eJ32 `data_o_o`)
- `tx_o`  out  1  serial line, idle high
- `busy_o`  out  1  high while a frame is being shifted (state ≠ IDLE)
- `full_o`  out  1  FIFO holds DEPTH entries
- `ovf_o`  out  1  sticky: a captured byte was dropped because the FIFO was full
- `cnt_o`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Capture: at each posedge with `write_i`=1 and OBUF ≤ `addr_i` < OBUF+OBSZ, push `data_i`. The compare is unsigned, full ASZ width. Writes outside the window are ignored. Address order is not checked: bytes are transmitted in write order, not address order.
- Full: a push while `cnt_o`=DEPTH and no pop that cycle drops the byte and sets `ovf_o`. A push and a pop in the same cycle while full are both accepted; count stays DEPTH and `ovf_o` is unchanged.
- Empty: a pop requires `cnt_o`>0 before the edge. A byte pushed at edge N is not popped before edge N+1, so there is no bypass.
- TX FSM states IDLE, START, DATA, STOP. It uses a baud counter `bc` (0..DIV-1), bit index `bi` (0..7) and an 8-bit shifter.
  - IDLE: `tx_o`=1. If FIFO is non-empty: pop into the shifter, set `bc`=0, go to START.
  - START: `tx_o`=0 for DIV cycles, then go to DATA with `bi`=0.
  - DATA: `tx_o`=shifter[0], LSB first. Each bit is held DIV cycles, then the shifter shifts right and `bi` increments. After bit 7 go to STOP.
  - STOP: `tx_o`=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START with no idle gap. Otherwise go to IDLE.
- `tx_o` is a registered output, driven from the state register.
- Reset (including mid-frame):
  - FSM to IDLE, `tx_o`=1, FIFO cleared (`cnt_o`=0).
  - `ovf_o`=0, `busy_o`=0, `full_o`=0, `bc`=`bi`=0.
  - A partial frame is truncated, not completed.
  - A write coincident with `rst` is discarded.
- FIFO pointers wrap modulo DEPTH. The count has one extra bit so that full and empty are distinguishable.

## Timing
- Capture latency: a write at edge N makes `cnt_o` increment after edge N.
- Start latency: with the FSM idle, `tx_o` falls after edge N+1 (pop edge), and `busy_o` rises on the same edge.
- Frame length: exactly 10·DIV cycles (40 at DIV=4). Back-to-back frames are contiguous.
- Sustained drain rate is 1 byte per 10·DIV cycles. The core is never stalled; overrun shows only via `ovf_o`.
- `full_o` and `cnt_o` reflect the state after the most recent edge.

## Test plan
- Single byte: write 'h41 to 'h1400 at edge 0. Required: `tx_o` low for cycles 1-4, then bits 1,0,0,0,0,0,1,0 at 4 cycles each (cycles 5-36), then high for cycles 37-40. `busy_o` is high for cycles 1-40, `cnt_o` returns to 0 after edge 1.
- Window bounds: writes to 'h13ff and 'h1a00 are ignored (`cnt_o` stays 0, `tx_o` stays 1). Writes to 'h1400 and 'h19ff are both captured and transmitted in order.
- Back-to-back: write "ok" ('h6f, 'h6b) on consecutive edges. Required: two frames totalling 80 cycles with no idle-high gap beyond the stop bit, decoded as 'h6f then 'h6b.
- Overflow: 18 in-window writes on consecutive edges 0-17 with DEPTH=16. The FIFO reaches 16 after edge 16, and the write at edge 17 is dropped. Required: `ovf_o`=1 and `full_o`=1, the first 17 bytes transmit correctly, the 18th never appears.
- Reset mid-frame: assert `rst` for one cycle at cycle 15 of a frame with 3 bytes queued. Required: after that edge `tx_o`=1, `cnt_o`=0, `busy_o`=0, `ovf_o`=0. A new write afterwards produces a clean frame.
- Non-write traffic: reads (`write_i`=0) to 'h1400 with arbitrary `data_i` cause no capture.
